jt51_op_sched: RTL and testbench

//  Slot scheduler and connection controller for the jt51 operator pipeline.
//  - Walks the 32 operator slots: 4 groups (M1, M2, C1, C2) x 8 channels.
//  - Holds the per-channel CON (algorithm) and FB (feedback) registers.
//  - Drives the pipeline's slot-entry flags, modulation-source selects, con_I and fb_II.
//  - Sits between the MMR write path and the operator pipeline; it is the only source of those pipeline controls.

---
 rtl/jt51_op_sched_pkg.sv | 40 ++++
 rtl/jt51_op_sched_if.sv | 36 +++
 rtl/jt51_con_dec.sv | 53 +++++
 rtl/jt51_op_sched.sv | 83 ++++++++
 tb/tb_jt51_op_sched.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/jt51_op_sched_pkg.sv
// Shared definitions for the jt51 operator slot scheduler: group codes,
// modulation-select bit order and the registered output bundle.
package jt51_op_sched_pkg;

  localparam logic [1:0] GRP_M1 = 2'd0;
  localparam logic [1:0] GRP_M2 = 2'd1;
  localparam logic [1:0] GRP_C1 = 2'd2;
  localparam logic [1:0] GRP_C2 = 2'd3;

  // Select vector bit order {prevprev1, prev1, prev2, internal_x, internal_y}
  localparam int SEL_PP1 = 4;
  localparam int SEL_P1  = 3;
  localparam int SEL_P2  = 2;
  localparam int SEL_IX  = 1;
  localparam int SEL_IY  = 0;

  typedef logic [4:0] sel_t;

  typedef struct packed {
    logic [4:0] slot;
    logic       zero;
    logic [3:0] enters;   // {m1, m2, c1, c2}
    logic [2:0] con;
    logic [2:0] fb;
    sel_t       sel;
  } sched_out_t;

  function automatic logic [3:0] grp_onehot(input logic [1:0] grp);
    logic [3:0] oh;
    oh = '0;
    case (grp)
      GRP_M1:  oh = 4'b1000;
      GRP_M2:  oh = 4'b0100;
      GRP_C1:  oh = 4'b0010;
      default: oh = 4'b0001;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/jt51_op_sched_if.sv
// Config write bus and pipeline control outputs of the operator scheduler.
interface jt51_op_sched_if;
  logic       cen;
  logic       cfg_we;
  logic [2:0] cfg_ch;
  logic [2:0] cfg_con;
  logic [2:0] cfg_fb;

  logic [4:0] slot_I;
  logic       zero;
  logic       m1_enters;
  logic       m2_enters;
  logic       c1_enters;
  logic       c2_enters;
  logic [2:0] con_I;
  logic [2:0] fb_II;
  logic       use_prevprev1;
  logic       use_prev1;
  logic       use_prev2;
  logic       use_internal_x;
  logic       use_internal_y;

  modport master (
    output cen, cfg_we, cfg_ch, cfg_con, cfg_fb,
    input  slot_I, zero, m1_enters, m2_enters, c1_enters, c2_enters,
           con_I, fb_II, use_prevprev1, use_prev1, use_prev2,
           use_internal_x, use_internal_y
  );

  modport slave (
    input  cen, cfg_we, cfg_ch, cfg_con, cfg_fb,
    output slot_I, zero, m1_enters, m2_enters, c1_enters, c2_enters,
           con_I, fb_II, use_prevprev1, use_prev1, use_prev2,
           use_internal_x, use_internal_y
  );
endinterface

// File: rtl/jt51_con_dec.sv
// Combinational decode of (group, CON) into the five modulation-source selects.
module jt51_con_dec
  import jt51_op_sched_pkg::*;
(
  input  logic [1:0] grp,
  input  logic [2:0] con,
  output sel_t       sel
);

  // x sources are {prevprev1, prev2, internal_x}, y sources {prev1, internal_y}
  always_comb begin
    sel = '0;
    case (grp)
      GRP_M1: begin
        sel[SEL_PP1] = 1'b1;
        sel[SEL_P1]  = 1'b1;
      end
      GRP_M2: begin
        case (con)
          3'd0, 3'd2: sel[SEL_P2] = 1'b1;
          3'd1: begin
            sel[SEL_P2] = 1'b1;
            sel[SEL_P1] = 1'b1;
          end
          3'd5:    sel[SEL_PP1] = 1'b1;
          default: sel = '0;
        endcase
      end
      GRP_C1: begin
        case (con)
          3'd0, 3'd3, 3'd4, 3'd5, 3'd6: sel[SEL_IY] = 1'b1;
          default: sel = '0;
        endcase
      end
      default: begin
        case (con)
          3'd0, 3'd1, 3'd4: sel[SEL_IX] = 1'b1;
          3'd2: begin
            sel[SEL_IX] = 1'b1;
            sel[SEL_P1] = 1'b1;
          end
          3'd3: begin
            sel[SEL_P2] = 1'b1;
            sel[SEL_IY] = 1'b1;
          end
          3'd5:    sel[SEL_P1] = 1'b1;
          default: sel = '0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/jt51_op_sched.sv
// Slot scheduler for the jt51 operator pipeline: walks 32 slots, holds the
// per-channel CON/FB registers and drives registered pipeline controls.
module jt51_op_sched
  import jt51_op_sched_pkg::*;
#(
  parameter bit SNAPSHOT_CON = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  jt51_op_sched_if.slave    bus
);

  logic [4:0] cnt;
  logic [2:0] con_rf [8];
  logic [2:0] fb_rf  [8];
  logic [2:0] snap   [8];
  sched_out_t out_p0;

  logic [1:0] grp;
  logic [2:0] ch;
  logic [2:0] con_eff;
  sel_t       sel_nxt;

  assign grp = cnt[4:3];
  assign ch  = cnt[2:0];

  // Regfile reads see the pre-edge contents, so a same-cycle write is not visible
  always_comb begin
    con_eff = con_rf[ch];
    if (SNAPSHOT_CON && (grp != GRP_M1))
      con_eff = snap[ch];
  end

  jt51_con_dec u_dec (
    .grp (grp),
    .con (con_eff),
    .sel (sel_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      out_p0 <= '0;
      for (int i = 0; i < 8; i++) begin
        con_rf[i] <= '0;
        fb_rf[i]  <= '0;
        snap[i]   <= '0;
      end
    end else begin
      // Slot decode -> output register stage
      if (bus.cen) begin
        out_p0.slot   <= cnt;
        out_p0.zero   <= (cnt == 5'd0);
        out_p0.enters <= grp_onehot(grp);
        out_p0.con    <= con_eff;
        out_p0.fb     <= fb_rf[out_p0.slot[2:0]];
        out_p0.sel    <= sel_nxt;
        if (grp == GRP_M1)
          snap[ch] <= con_rf[ch];
        cnt <= cnt + 5'd1;
      end
      if (bus.cfg_we) begin
        con_rf[bus.cfg_ch] <= bus.cfg_con;
        fb_rf[bus.cfg_ch]  <= bus.cfg_fb;
      end
    end
  end

  assign bus.slot_I         = out_p0.slot;
  assign bus.zero           = out_p0.zero;
  assign bus.m1_enters      = out_p0.enters[3];
  assign bus.m2_enters      = out_p0.enters[2];
  assign bus.c1_enters      = out_p0.enters[1];
  assign bus.c2_enters      = out_p0.enters[0];
  assign bus.con_I          = out_p0.con;
  assign bus.fb_II          = out_p0.fb;
  assign bus.use_prevprev1  = out_p0.sel[SEL_PP1];
  assign bus.use_prev1      = out_p0.sel[SEL_P1];
  assign bus.use_prev2      = out_p0.sel[SEL_P2];
  assign bus.use_internal_x = out_p0.sel[SEL_IX];
  assign bus.use_internal_y = out_p0.sel[SEL_IY];

endmodule

// File: tb/tb_jt51_op_sched.sv
// Scoreboard bench for jt51_op_sched: a cycle model predicts each cen's outputs.
module tb_jt51_op_sched;
  import jt51_op_sched_pkg::*;

  logic clk;
  logic rst;
  jt51_op_sched_if bus ();

  jt51_op_sched #(.SNAPSHOT_CON(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [1:0] dg;
  logic [2:0] dc;
  sel_t       dsel;
  jt51_con_dec u_ref (.grp(dg), .con(dc), .sel(dsel));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [20:0] obs_w = {bus.slot_I, bus.zero, bus.m1_enters, bus.m2_enters,
                       bus.c1_enters, bus.c2_enters, bus.con_I, bus.fb_II,
                       bus.use_prevprev1, bus.use_prev1, bus.use_prev2,
                       bus.use_internal_x, bus.use_internal_y};

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0] m_cnt;
  logic [2:0] m_con  [8];
  logic [2:0] m_fb   [8];
  logic [2:0] m_snap [8];
  sched_out_t m_last;
  sched_out_t sb [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Select table written out independently of the RTL decoder
  function automatic sel_t ref_sel(input logic [1:0] g, input logic [2:0] c);
    case (g)
      2'd0: return 5'b11000;
      2'd1: case (c)
              3'd0, 3'd2: return 5'b00100;
              3'd1:       return 5'b01100;
              3'd5:       return 5'b10000;
              default:    return 5'b00000;
            endcase
      2'd2: case (c)
              3'd1, 3'd2, 3'd7: return 5'b00000;
              default:          return 5'b00001;
            endcase
      default: case (c)
              3'd0, 3'd1, 3'd4: return 5'b00010;
              3'd2:             return 5'b01010;
              3'd3:             return 5'b00101;
              3'd5:             return 5'b01000;
              default:          return 5'b00000;
            endcase
    endcase
  endfunction

  task automatic model_clear();
    m_cnt  = '0;
    m_last = '0;
    sb.delete();
    for (int i = 0; i < 8; i++) begin
      m_con[i] = '0; m_fb[i] = '0; m_snap[i] = '0;
    end
  endtask

  task automatic tick(input bit c, input bit we, input logic [2:0] ch,
                      input logic [2:0] con, input logic [2:0] fb);
    sched_out_t e;
    logic [1:0] g;
    logic [2:0] mc;
    @(negedge clk);
    bus.cen = c; bus.cfg_we = we; bus.cfg_ch = ch; bus.cfg_con = con; bus.cfg_fb = fb;
    if (c) begin
      g  = m_cnt[4:3];
      mc = m_cnt[2:0];
      e.slot   = m_cnt;
      e.zero   = (m_cnt == 5'd0);
      e.enters = 4'b1000 >> g;
      e.con    = (g == 2'd0) ? m_con[mc] : m_snap[mc];
      e.fb     = m_fb[m_last.slot[2:0]];
      e.sel    = ref_sel(g, e.con);
      sb.push_back(e);
      if (g == 2'd0) m_snap[mc] = m_con[mc];
      m_cnt  = m_cnt + 5'd1;
      m_last = e;
    end
    if (we) begin
      m_con[ch] = con;
      m_fb[ch]  = fb;
    end
    @(posedge clk);
    #1;
    if (c) begin
      e = sb.pop_front();
      chk("sb", 32'(obs_w), 32'(e));
    end else begin
      chk("hold", 32'(obs_w), 32'(m_last));
    end
  endtask

  task automatic run_to(input logic [4:0] s);
    for (int k = 0; k < 64 && m_last.slot != s; k++) tick(1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
    chk("run_to", 32'(bus.slot_I), 32'(s));
  endtask

  task automatic do_reset(input bit c);
    @(negedge clk);
    rst = 1'b1; bus.cen = c; bus.cfg_we = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out", 32'(obs_w), 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0; bus.cen = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    bus.cen = 1'b0; bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_con = '0; bus.cfg_fb = '0;
    dg = '0; dc = '0;
    model_clear();

    // Decoder against the independent table
    for (int i = 0; i < 32; i++) begin
      dg = i[4:3]; dc = i[2:0];
      #1;
      chk("dec_table", 32'(dsel), 32'(ref_sel(dg, dc)));
    end

    // 1: reset and free-running walk
    repeat (2) @(posedge clk);
    do_reset(1'b1);
    tick(1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
    chk("t1_zero", 32'({bus.zero, bus.m1_enters, bus.use_prevprev1, bus.use_prev1}), 32'hF);
    chk("t1_slot", 32'(bus.slot_I), 32'd0);
    run_to(5'd8);
    chk("t1_m2", 32'({bus.m1_enters, bus.m2_enters, bus.c1_enters, bus.c2_enters}), 32'b0100);
    run_to(5'd0);
    k = 0;
    do begin
      tick(1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
      k++;
    end while (!bus.zero && k < 40);
    chk("t1_period", 32'(k), 32'd32);

    // 2: ch3 con=1 fb=5
    tick(1'b0, 1'b1, 3'd3, 3'd1, 3'd5);
    run_to(5'd31);
    run_to(5'd3);
    tick(1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
    chk("t2_fb", 32'(bus.fb_II), 32'd5);
    run_to(5'd11);
    chk("t2_sel", 32'(obs_w[4:0]), 32'b01100);

    // 3: CON snapshot holds through the frame
    tick(1'b0, 1'b1, 3'd2, 3'd0, 3'd0);
    run_to(5'd31);
    run_to(5'd10);
    tick(1'b1, 1'b1, 3'd2, 3'd7, 3'd0);
    run_to(5'd18);
    chk("t3_iy_old", 32'({bus.use_internal_y, bus.con_I}), 32'b1000);
    run_to(5'd31);
    run_to(5'd18);
    chk("t3_sel_new", 32'(obs_w[4:0]), 32'd0);
    chk("t3_con_new", 32'(bus.con_I), 32'd7);

    // 4: cen at 1/3 duty
    for (int i = 0; i < 30; i++) tick((i % 3) == 0, 1'b0, 3'd0, 3'd0, 3'd0);

    // 6: sweep con on ch0
    run_to(5'd31);
    for (int v = 0; v < 8; v++) begin
      tick(1'b0, 1'b1, 3'd0, v[2:0], 3'd0);
      for (int j = 0; j < 32; j++) begin
        tick(1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
        if ((j % 8) == 0) begin
          chk("t6_sel", 32'(obs_w[4:0]), 32'(ref_sel(j[4:3], v[2:0])));
          chk("t6_con", 32'(bus.con_I), 32'(v));
        end
        chk("t6_x_excl",
            32'(($countones({bus.use_prevprev1, bus.use_prev2, bus.use_internal_x}) > 1) ? 1 : 0), 32'd0);
        chk("t6_y_excl",
            32'(($countones({bus.use_prev1, bus.use_internal_y}) > 1) ? 1 : 0), 32'd0);
      end
    end
    // Same-clk write and M1 read of ch0 returns the old CON
    tick(1'b1, 1'b1, 3'd0, 3'd3, 3'd6);
    chk("collide_con", 32'(bus.con_I), 32'd7);

    // 5: reset mid-frame with cen low
    run_to(5'd20);
    do_reset(1'b0);
    tick(1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
    chk("t5_slot0", 32'({bus.slot_I, bus.zero}), 32'd1);
    for (int j = 0; j < 33; j++) begin
      tick(1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
      chk("t5_confb", 32'({bus.con_I, bus.fb_II}), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
